// File: rtl/rst_seq_buf.sv
// rst_seq_buf: distributes reset, scan-enable and debug-init to N_CH clusters.
// The reset and debug-init requests are synchronised to rclk, and the
// per-channel resets are then released one channel at a time, lowest index
// first, with STAGGER_CYC cycles between releases.
// Optional build macro SCAN_RST_BYPASS_EN: while se=1, every rst_l_buf bit
// and adbginit_l_buf follow arst_l combinationally, for ATPG control.
//
// state   | meaning
// --------+------------------------------------------------------------
// HOLD    | all channels held in reset, waiting for synchronised rst_l
// STAGGER | releasing channels one at a time, STAGGER_CYC cycles apart
// DONE    | all channels released; stays here until rst_l is re-asserted
module rst_seq_buf #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STAGGER_CYC = 8
) (
    input  logic            rclk,
    input  logic            arst_l,
    input  logic            rst_l,
    input  logic            se,
    input  logic            adbginit_l,
    output logic [N_CH-1:0] rst_l_buf,
    output logic            se_buf,
    output logic            adbginit_l_buf,
    output logic            seq_done
);

    localparam int CNT_W = $clog2(STAGGER_CYC + 1);
    localparam int IDX_W = $clog2(N_CH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGGER_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CH - 1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STAGGER = 2'd1,
        DONE    = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] rst_sync_q;
    logic [SYNC_STAGES-1:0] dbg_sync_q;
    logic                   rst_s;
    logic                   dbg_s;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       ch_idx_q, ch_idx_d;
    logic [N_CH-1:0]        rel_q, rel_d;
    logic                   done_q, done_d;
    logic                   dbg_q, dbg_d;

    // Synchronise both asynchronous requests; chains reset to "asserted".
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            rst_sync_q <= '0;
            dbg_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], rst_l};
            dbg_sync_q <= {dbg_sync_q[SYNC_STAGES-2:0], adbginit_l};
        end
    end

    assign rst_s = rst_sync_q[SYNC_STAGES-1];
    assign dbg_s = dbg_sync_q[SYNC_STAGES-1];

    // Sequencer state, stagger timer, channel index and registered outputs.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state_q  <= HOLD;
            cnt_q    <= '0;
            ch_idx_q <= '0;
            rel_q    <= '0;
            done_q   <= 1'b0;
            dbg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ch_idx_q <= ch_idx_d;
            rel_q    <= rel_d;
            done_q   <= done_d;
            dbg_q    <= dbg_d;
        end
    end

    // Next-state logic; a synchronised re-assertion beats any pending release.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ch_idx_d = ch_idx_q;
        rel_d    = rel_q;
        done_d   = done_q;

        case (state_q)
            HOLD: begin
                rel_d    = '0;
                done_d   = 1'b0;
                cnt_d    = '0;
                ch_idx_d = '0;
                if (rst_s) begin
                    state_d = STAGGER;
                end
            end
            STAGGER: begin
                if (!rst_s) begin
                    state_d  = HOLD;
                    rel_d    = '0;
                    done_d   = 1'b0;
                    cnt_d    = '0;
                    ch_idx_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    rel_d    = rel_q | (N_CH'(1) << ch_idx_q);
                    cnt_d    = '0;
                    ch_idx_d = ch_idx_q + 1'b1;
                    if (ch_idx_q == IDX_LAST) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (!rst_s) begin
                    state_d  = HOLD;
                    rel_d    = '0;
                    done_d   = 1'b0;
                    cnt_d    = '0;
                    ch_idx_d = '0;
                end else begin
                    rel_d  = '1;
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d  = HOLD;
                rel_d    = '0;
                done_d   = 1'b0;
                cnt_d    = '0;
                ch_idx_d = '0;
            end
        endcase
    end

    // Debug-init is only passed through once the sequencer has left HOLD.
    always_comb begin
        dbg_d = dbg_s & (state_d != HOLD);
    end

    assign se_buf   = se;
    assign seq_done = done_q;

`ifdef SCAN_RST_BYPASS_EN
    assign rst_l_buf      = se ? {N_CH{arst_l}} : rel_q;
    assign adbginit_l_buf = se ? arst_l : dbg_q;
`else
    assign rst_l_buf      = rel_q;
    assign adbginit_l_buf = dbg_q;
`endif

endmodule

// File: tb/tb_rst_seq_buf.sv
// Testbench for rst_seq_buf: default-parameter instance plus an N_CH=1,
// STAGGER_CYC=1 instance sharing the same inputs.
module tb_rst_seq_buf;

    logic       rclk = 1'b0;
    logic       arst_l;
    logic       rst_l;
    logic       se;
    logic       adbginit_l;
    logic [3:0] rst_l_buf;
    logic       se_buf;
    logic       adbginit_l_buf;
    logic       seq_done;
    logic [0:0] rb1;
    logic       se_buf1;
    logic       adbg1;
    logic       done1;

    int checks   = 0;
    int errors   = 0;
    int edge_cnt = 0;

`ifdef SCAN_RST_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        int         edge_no;
        logic [3:0] val;
        logic       done;
    } exp_t;

    exp_t sb[$];

    rst_seq_buf #(.N_CH(4), .SYNC_STAGES(2), .STAGGER_CYC(8)) dut (
        .rclk           (rclk),
        .arst_l         (arst_l),
        .rst_l          (rst_l),
        .se             (se),
        .adbginit_l     (adbginit_l),
        .rst_l_buf      (rst_l_buf),
        .se_buf         (se_buf),
        .adbginit_l_buf (adbginit_l_buf),
        .seq_done       (seq_done)
    );

    rst_seq_buf #(.N_CH(1), .SYNC_STAGES(2), .STAGGER_CYC(1)) dut1 (
        .rclk           (rclk),
        .arst_l         (arst_l),
        .rst_l          (rst_l),
        .se             (se),
        .adbginit_l     (adbginit_l),
        .rst_l_buf      (rb1),
        .se_buf         (se_buf1),
        .adbginit_l_buf (adbg1),
        .seq_done       (done1)
    );

    always #5 rclk = ~rclk;

    always @(posedge rclk) edge_cnt <= edge_cnt + 1;

    task automatic cycles(input int n);
        repeat (n) @(negedge rclk);
    endtask

    // Expected releases: channel k at edge (k+1)*8 after STAGGER entry at edge 3.
    task automatic push_seq(input int n);
        exp_t       e;
        logic [4:0] t;
        for (int k = 0; k < n; k++) begin
            t         = (5'd1 << (k + 1)) - 5'd1;
            e.edge_no = (k + 1) * 8 + 3;
            e.val     = t[3:0];
            e.done    = (k == 3);
            sb.push_back(e);
        end
    endtask

    task automatic watch(input int base, input int budget);
        logic [3:0] prev;
        exp_t       e;
        int         rel;
        prev = rst_l_buf;
        for (int i = 0; i < budget && sb.size() > 0; i++) begin
            @(negedge rclk);
            rel = edge_cnt - base;
            if (rel == 3) begin
                checks++;
                if (rb1 !== 1'b0 || done1 !== 1'b0) begin
                    errors++;
                    $display("FAIL n1_pre_release: got buf=%b done=%b expected buf=0 done=0", rb1, done1);
                end
            end
            if (rel == 4) begin
                checks++;
                if (rb1 !== 1'b1 || done1 !== 1'b1) begin
                    errors++;
                    $display("FAIL n1_release: got buf=%b done=%b expected buf=1 done=1", rb1, done1);
                end
            end
            if (rst_l_buf !== prev) begin
                e = sb.pop_front();
                checks++;
                if (rst_l_buf !== e.val || rel !== e.edge_no || seq_done !== e.done) begin
                    errors++;
                    $display("FAIL release_step: got buf=%b edge=%0d done=%b expected buf=%b edge=%0d done=%b",
                             rst_l_buf, rel, seq_done, e.val, e.edge_no, e.done);
                end
                prev = rst_l_buf;
            end
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL release_timeout: got %0d releases pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        cycles(3);
        checks++;
        if (rst_l_buf !== 4'h0 || seq_done !== 1'b0 || adbginit_l_buf !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got buf=%b done=%b dbg=%b expected 0000 0 0",
                     rst_l_buf, seq_done, adbginit_l_buf);
        end
        checks++;
        if (rb1 !== 1'b0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_n1: got buf=%b done=%b expected 0 0", rb1, done1);
        end
    endtask

    task automatic test_sequence();
        int base;
        arst_l = 1'b1;
        base   = edge_cnt;
        push_seq(4);
        watch(base, 45);
        cycles(2);
        checks++;
        if (rst_l_buf !== 4'hF || seq_done !== 1'b1) begin
            errors++;
            $display("FAIL done_hold: got buf=%b done=%b expected 1111 1", rst_l_buf, seq_done);
        end
    endtask

    task automatic test_adbginit();
        adbginit_l = 1'b1;
        cycles(2);
        checks++;
        if (adbginit_l_buf !== 1'b0) begin
            errors++;
            $display("FAIL dbg_latency_early: got %b expected 0", adbginit_l_buf);
        end
        cycles(1);
        checks++;
        if (adbginit_l_buf !== 1'b1 || adbg1 !== 1'b1) begin
            errors++;
            $display("FAIL dbg_release: got %b/%b expected 1/1", adbginit_l_buf, adbg1);
        end
    endtask

    task automatic test_reassert();
        int base;
        rst_l = 1'b0;
        cycles(2);
        checks++;
        if (rst_l_buf !== 4'hF) begin
            errors++;
            $display("FAIL reassert_early: got %b expected 1111", rst_l_buf);
        end
        cycles(1);
        checks++;
        if (rst_l_buf !== 4'h0 || seq_done !== 1'b0 || adbginit_l_buf !== 1'b0) begin
            errors++;
            $display("FAIL reassert_done: got buf=%b done=%b dbg=%b expected 0000 0 0",
                     rst_l_buf, seq_done, adbginit_l_buf);
        end
        cycles(3);
        checks++;
        if (adbginit_l_buf !== 1'b0) begin
            errors++;
            $display("FAIL dbg_hold_forced: got %b expected 0", adbginit_l_buf);
        end
        rst_l = 1'b1;
        base  = edge_cnt;
        push_seq(2);
        watch(base, 25);
        rst_l = 1'b0;
        cycles(2);
        checks++;
        if (rst_l_buf !== 4'h3) begin
            errors++;
            $display("FAIL reassert_stagger_early: got %b expected 0011", rst_l_buf);
        end
        cycles(1);
        checks++;
        if (rst_l_buf !== 4'h0 || seq_done !== 1'b0) begin
            errors++;
            $display("FAIL reassert_stagger: got buf=%b done=%b expected 0000 0", rst_l_buf, seq_done);
        end
        cycles(2);
        rst_l = 1'b1;
        base  = edge_cnt;
        push_seq(4);
        watch(base, 45);
    endtask

    task automatic test_async_reset();
        int base;
        rst_l = 1'b0;
        cycles(4);
        rst_l = 1'b1;
        base  = edge_cnt;
        push_seq(3);
        watch(base, 35);
        checks++;
        if (rst_l_buf !== 4'h7) begin
            errors++;
            $display("FAIL async_pre: got %b expected 0111", rst_l_buf);
        end
        #2 arst_l = 1'b0;
        #1;
        checks++;
        if (rst_l_buf !== 4'h0 || seq_done !== 1'b0 || adbginit_l_buf !== 1'b0 ||
            rb1 !== 1'b0 || done1 !== 1'b0 || adbg1 !== 1'b0) begin
            errors++;
            $display("FAIL async_clear: got buf=%b done=%b dbg=%b n1=%b%b%b expected all 0",
                     rst_l_buf, seq_done, adbginit_l_buf, rb1, done1, adbg1);
        end
        @(negedge rclk);
        arst_l = 1'b1;
        base   = edge_cnt;
        push_seq(4);
        cycles(1);
        checks++;
        if (rst_l_buf !== 4'h0 || adbginit_l_buf !== 1'b0) begin
            errors++;
            $display("FAIL async_refill: got buf=%b dbg=%b expected 0000 0", rst_l_buf, adbginit_l_buf);
        end
        watch(base, 44);
    endtask

    task automatic test_scan();
        logic [3:0] exp_buf;
        rst_l = 1'b0;
        cycles(5);
        exp_buf = BYP ? 4'hF : 4'h0;
        se = 1'b1;
        #1;
        checks++;
        if (se_buf !== 1'b1 || se_buf1 !== 1'b1) begin
            errors++;
            $display("FAIL se_follow_hi: got %b/%b expected 1/1", se_buf, se_buf1);
        end
        checks++;
        if (rst_l_buf !== exp_buf || adbginit_l_buf !== BYP || rb1 !== BYP || seq_done !== 1'b0) begin
            errors++;
            $display("FAIL scan_bypass: got buf=%b dbg=%b n1=%b done=%b expected buf=%b dbg=%b n1=%b done=0",
                     rst_l_buf, adbginit_l_buf, rb1, seq_done, exp_buf, BYP, BYP);
        end
        se = 1'b0;
        #1;
        checks++;
        if (se_buf !== 1'b0 || rst_l_buf !== 4'h0 || adbginit_l_buf !== 1'b0 || rb1 !== 1'b0) begin
            errors++;
            $display("FAIL scan_revert: got se=%b buf=%b dbg=%b n1=%b expected 0 0000 0 0",
                     se_buf, rst_l_buf, adbginit_l_buf, rb1);
        end
    endtask

    initial begin
        arst_l     = 1'b0;
        rst_l      = 1'b1;
        se         = 1'b0;
        adbginit_l = 1'b0;
        test_reset();
        test_sequence();
        test_adbginit();
        test_reassert();
        test_async_reset();
        test_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
